// File: rtl/transport_clock.sv
// Master transport for the drum machine: divides audio_tick into swung 16th-note
// advance pulses and provides play/pause/stop control plus step/beat/bar position.
module transport_clock #(
    parameter int SPS_W       = 16,
    parameter int STEPS       = 16,
    parameter int DEFAULT_SPS = 6000,
    parameter int MIN_SPS     = 8
) (
    input  logic                       audio_tick,
    input  logic                       reset,
    input  logic                       cmd_play,
    input  logic                       cmd_stop,
    input  logic [SPS_W-1:0]           sps_in,
    input  logic                       sps_load,
    input  logic [3:0]                 swing,
    output logic                       advance,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       beat,
    output logic                       bar_start,
    output logic                       running,
    output logic                       paused
);

    localparam int IDX_W = $clog2(STEPS);
    localparam logic [SPS_W-1:0] DEFAULT_SPS_C = SPS_W'(DEFAULT_SPS);
    localparam logic [SPS_W-1:0] MIN_SPS_C     = SPS_W'(MIN_SPS);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic               start_r;
    logic               first_r;
    logic [SPS_W:0]     cnt_r;
    logic [SPS_W:0]     period_r;
    logic [SPS_W-1:0]   sps_reg_r;
    logic [SPS_W-1:0]   pending_r;
    logic [3:0]         swing_reg_r;
    logic [IDX_W-1:0]   step_idx_r;
    logic               advance_r;
    logic               beat_r;
    logic               bar_start_r;
    logic               running_r;
    logic               paused_r;

    logic               running_s;
    logic               boundary_s;
    logic               apply_s;
    logic [SPS_W-1:0]   sps_eff_s;
    logic [3:0]         swing_eff_s;
    logic [SPS_W+4:0]   prod_s;
    logic [SPS_W-1:0]   off_s;
    logic [IDX_W-1:0]   step_nxt_s;
    logic [SPS_W:0]     period_nxt_s;
    logic [SPS_W-1:0]   sps_clamp_s;

    // Transport next-state; a stop request always beats a simultaneous play
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_STOPPED: begin
                if (cmd_stop)      state_nxt_s = ST_STOPPED;
                else if (cmd_play) state_nxt_s = ST_RUNNING;
                else               state_nxt_s = ST_STOPPED;
            end
            ST_RUNNING: begin
                if (cmd_stop) state_nxt_s = ST_PAUSED;
                else          state_nxt_s = ST_RUNNING;
            end
            ST_PAUSED: begin
                if (cmd_stop)      state_nxt_s = ST_STOPPED;
                else if (cmd_play) state_nxt_s = ST_RUNNING;
                else               state_nxt_s = ST_PAUSED;
            end
            default: state_nxt_s = ST_STOPPED;
        endcase
    end

    // Step boundary detection and the period of the step that starts there
    always_comb begin
        running_s  = (state_r == ST_RUNNING);
        boundary_s = running_s && !cmd_stop &&
                     (start_r || (cnt_r == (period_r - (SPS_W+1)'(1))));
        apply_s    = boundary_s || !running_s;
        if (apply_s) begin
            sps_eff_s   = pending_r;
            swing_eff_s = swing;
        end else begin
            sps_eff_s   = sps_reg_r;
            swing_eff_s = swing_reg_r;
        end
        // The new step uses the values being applied at this boundary
        prod_s = (SPS_W+5)'(sps_eff_s) * (SPS_W+5)'(swing_eff_s);
        off_s  = SPS_W'(prod_s >> 5);
        if (first_r) step_nxt_s = '0;
        else         step_nxt_s = step_idx_r + IDX_W'(1);
        if (step_nxt_s[0] == 1'b0) period_nxt_s = {1'b0, sps_eff_s} + {1'b0, off_s};
        else                       period_nxt_s = {1'b0, sps_eff_s} - {1'b0, off_s};
        if (sps_in < MIN_SPS_C) sps_clamp_s = MIN_SPS_C;
        else                    sps_clamp_s = sps_in;
    end

    // Transport state, phase counter, tempo registers and registered outputs
    always_ff @(posedge audio_tick or posedge reset) begin
        if (reset) begin
            state_r     <= ST_STOPPED;
            start_r     <= 1'b0;
            first_r     <= 1'b1;
            cnt_r       <= '0;
            period_r    <= {1'b0, DEFAULT_SPS_C};
            sps_reg_r   <= DEFAULT_SPS_C;
            pending_r   <= DEFAULT_SPS_C;
            swing_reg_r <= 4'd0;
            step_idx_r  <= '0;
            advance_r   <= 1'b0;
            beat_r      <= 1'b0;
            bar_start_r <= 1'b0;
            running_r   <= 1'b0;
            paused_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            start_r     <= (state_nxt_s == ST_RUNNING) && !running_s;
            advance_r   <= boundary_s;
            beat_r      <= boundary_s && (step_nxt_s[1:0] == 2'b00);
            bar_start_r <= boundary_s && (step_nxt_s == '0);
            running_r   <= (state_nxt_s == ST_RUNNING);
            paused_r    <= (state_nxt_s == ST_PAUSED);
            if (sps_load) pending_r <= sps_clamp_s;
            if (apply_s) begin
                sps_reg_r   <= pending_r;
                swing_reg_r <= swing;
            end
            if (boundary_s) begin
                step_idx_r <= step_nxt_s;
                first_r    <= 1'b0;
                cnt_r      <= '0;
                period_r   <= period_nxt_s;
            end else if ((state_r == ST_PAUSED) && cmd_stop) begin
                step_idx_r <= '0;
                first_r    <= 1'b1;
                cnt_r      <= '0;
            end else if (running_s && !cmd_stop) begin
                cnt_r <= cnt_r + (SPS_W+1)'(1);
            end
        end
    end

    assign advance   = advance_r;
    assign step_idx  = step_idx_r;
    assign beat      = beat_r;
    assign bar_start = bar_start_r;
    assign running   = running_r;
    assign paused    = paused_r;

endmodule

// File: tb/tb_transport_clock.sv
// Directed self-checking bench for transport_clock: timing, swing, pause/resume,
// tempo loading, command priority and asynchronous reset.
module tb_transport_clock;

    logic        audio_tick;
    logic        reset;
    logic        cmd_play;
    logic        cmd_stop;
    logic [15:0] sps_in;
    logic        sps_load;
    logic [3:0]  swing;
    logic        advance;
    logic [3:0]  step_idx;
    logic        beat;
    logic        bar_start;
    logic        running;
    logic        paused;

    int checks_r   = 0;
    int failures_r = 0;

    transport_clock #(
        .SPS_W(16), .STEPS(16), .DEFAULT_SPS(6000), .MIN_SPS(8)
    ) dut (
        .audio_tick(audio_tick), .reset(reset), .cmd_play(cmd_play),
        .cmd_stop(cmd_stop), .sps_in(sps_in), .sps_load(sps_load),
        .swing(swing), .advance(advance), .step_idx(step_idx), .beat(beat),
        .bar_start(bar_start), .running(running), .paused(paused)
    );

    initial audio_tick = 1'b0;
    always #5 audio_tick = ~audio_tick;

    task automatic chk(input string tag, input int got, input int exp);
        checks_r++;
        if (got != exp) begin
            failures_r++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge audio_tick);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step_clk();
    endtask

    // Ticks until the next advance; -1 if none within the bound
    task automatic wait_adv(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step_clk();
            if (advance) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic pulse_play();
        cmd_play = 1'b1; step_clk(); cmd_play = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; step_clk(); cmd_stop = 1'b0;
    endtask

    task automatic load_sps(input int v);
        sps_in = 16'(v); sps_load = 1'b1; step_clk(); sps_load = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        reset = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
        sps_in = 16'd0; sps_load = 1'b0; swing = 4'd0;
        #2 reset = 1'b1;
        #3;
        chk("rst_advance", advance, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_running", running, 0);
        chk("rst_paused", paused, 0);
        @(posedge audio_tick); #1 reset = 1'b0;

        // Straight 8-tick steps over a full bar
        load_sps(8);
        ticks(2);
        pulse_play();
        chk("play_running", running, 1);
        step_clk();
        chk("first_advance", advance, 1);
        chk("first_step", step_idx, 0);
        chk("first_bar", bar_start, 1);
        chk("first_beat", beat, 1);
        for (int k = 1; k <= 16; k++) begin
            wait_adv(n);
            chk("straight_ivl", n, 8);
            chk("straight_idx", step_idx, k % 16);
            chk("straight_beat", beat, (k % 4 == 0) ? 1 : 0);
            chk("straight_bar", bar_start, (k % 16 == 0) ? 1 : 0);
        end
        for (int k = 1; k <= 5; k++) wait_adv(n);
        chk("reach_step5", step_idx, 5);

        // Pause mid-step 5, idle 50 ticks, resume
        ticks(3);
        pulse_stop();
        chk("pause_paused", paused, 1);
        chk("pause_running", running, 0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step_clk();
            if (advance) cnt++;
        end
        chk("pause_no_adv", cnt, 0);
        chk("pause_hold_idx", step_idx, 5);
        pulse_play();
        step_clk();
        chk("resume_advance", advance, 1);
        chk("resume_idx", step_idx, 6);
        wait_adv(n);
        chk("resume_ivl", n, 8);

        // Stop twice rewinds to STOPPED
        pulse_stop();
        chk("stop1_paused", paused, 1);
        pulse_stop();
        chk("stop2_paused", paused, 0);
        chk("stop2_running", running, 0);
        chk("stop2_idx", step_idx, 0);

        // Simultaneous play and stop from STOPPED
        cmd_play = 1'b1; cmd_stop = 1'b1; step_clk();
        cmd_play = 1'b0; cmd_stop = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step_clk();
            if (advance) cnt++;
        end
        chk("both_no_adv", cnt, 0);
        chk("both_running", running, 0);

        // Swing: sps 16, swing 8 -> off 4, intervals 20/12
        load_sps(16);
        swing = 4'd8;
        ticks(2);
        pulse_play();
        step_clk();
        chk("swing_first_adv", advance, 1);
        for (int k = 0; k < 4; k++) begin
            wait_adv(n);
            chk("swing_ivl", n, (k % 2 == 0) ? 20 : 12);
        end

        // Tempo load mid-step, then a clamped load
        pulse_stop();
        pulse_stop();
        swing = 4'd0;
        load_sps(8);
        ticks(2);
        pulse_play();
        step_clk();
        chk("tempo_first_adv", advance, 1);
        ticks(3);
        load_sps(32);
        wait_adv(n);
        chk("tempo_cur_step", n + 4, 8);
        wait_adv(n);
        chk("tempo_new_ivl", n, 32);
        ticks(2);
        load_sps(3);
        wait_adv(n);
        chk("clamp_cur_step", n + 3, 32);
        wait_adv(n);
        chk("clamp_ivl", n, 8);
        chk("clamp_adv_seen", advance, 1);

        // Asynchronous reset while advance is high
        reset = 1'b1;
        #1;
        chk("async_advance", advance, 0);
        chk("async_running", running, 0);
        chk("async_step_idx", step_idx, 0);
        chk("async_bar", bar_start, 0);
        #3 reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule

// File: doc/transport_clock.md
Name: transport_clock

Overview:
- Master tempo and transport controller for the drum machine.
- Runs in the audio_tick domain and divides the sample-rate tick into 16th-note step pulses.
- Drives the shared `advance` input of every step sequencer lane, so all lanes stay step-locked.
- Provides play / pause / stop control, programmable tempo (samples per step), swing, and position outputs (step index, beat, bar) for the UI and LEDs.

Parameters:
- SPS_W, 16, width of the samples-per-step value and of the phase counter.
- STEPS, 16, steps per bar; must be a power of two, 4 to 64.
- DEFAULT_SPS, 6000, samples per step after reset (120 BPM 16ths at 48 kHz).
- MIN_SPS, 8, lower clamp for the loaded samples-per-step value.

Ports:
- audio_tick  in  1  clock, one rising edge per audio sample.
- reset  in  1  reset, asynchronous, active-high.
- cmd_play  in  1  one-tick pulse; start or resume.
- cmd_stop  in  1  one-tick pulse; pause, or stop-and-rewind if already paused.
- sps_in  in  SPS_W  new samples-per-step value.
- sps_load  in  1  one-tick pulse; latch sps_in.
- swing  in  4  swing amount, 0 to 15, in units of 1/32 step.
- advance  out  1  one-tick step pulse to the sequencers.
- step_idx  out  log2(STEPS)  index of the step whose advance pulse was last issued.
- beat  out  1  coincides with advance when step_idx mod 4 == 0.
- bar_start  out  1  coincides with advance when step_idx == 0.
- running  out  1  high in RUNNING.
- paused  out  1  high in PAUSED.

Behaviour:
- Reset (asynchronous, any time, including mid-step):
  - advance, beat, bar_start, running and paused = 0.
  - step_idx = 0, phase counter = 0.
  - State = STOPPED.
  - sps_reg = DEFAULT_SPS, pending value = DEFAULT_SPS, swing_reg = 0, first flag set.
- States: STOPPED, RUNNING, PAUSED. All transitions occur on the audio_tick rising edge.
- Transitions:
  - STOPPED + cmd_play → RUNNING. The first advance is asserted on the next tick with step_idx = 0 and bar_start = beat = 1.
  - PAUSED + cmd_play → RUNNING. advance is asserted on the next tick with step_idx = held index + 1 (wrapping), and the phase restarts at 0.
  - RUNNING + cmd_stop → PAUSED. Effective the tick it is sampled: no advance is issued from that tick on, and step_idx is held.
  - PAUSED + cmd_stop → STOPPED, with step_idx = 0.
  - STOPPED + cmd_stop: no effect.
  - RUNNING + cmd_play: ignored; no re-sync.
  - cmd_play and cmd_stop in the same tick: cmd_stop wins.
- Phase counter and step timing:
  - The counter counts ticks since the last advance.
  - When counter == period − 1, advance is asserted on the next tick, the counter returns to 0 and step_idx increments.
  - The period is fixed at the moment the step starts.
- Swing:
  - off = (sps_reg × swing_reg) >> 5, computed at full product width and then truncated to SPS_W bits.
  - Period after an even step_idx = sps_reg + off.
  - Period after an odd step_idx = sps_reg − off.
  - Each pair of steps therefore totals exactly 2 × sps_reg ticks.
  - swing = 0 gives a straight pulse every sps_reg ticks.
- Tempo loading:
  - sps_load stores max(sps_in, MIN_SPS) into a pending register.
  - Both sps_reg ← pending and swing_reg ← swing are applied only at a step boundary (the tick advance is asserted) or while not RUNNING.
  - A tempo change never truncates or lengthens the step in progress.
  - sps_load in the same tick as a boundary takes effect at the following boundary.
- step_idx wraps from STEPS−1 to 0; bar_start is asserted on that wrap.
- advance, beat and bar_start are registered, exactly one tick wide, and never asserted outside RUNNING.
- Arithmetic: sps_reg + off cannot exceed 1.47 × sps_reg. The period register is SPS_W+1 bits, so there is no overflow for any sps_in.

Test Plan:
- Reset, load sps_in = 8 with swing 0, then cmd_play at tick T:
  - advance at T+1, T+9, T+17, …
  - step_idx 0, 1, 2, …
  - bar_start at T+1 and at T+1+16×8.
  - beat on steps 0, 4, 8, 12.
- sps = 16, swing = 8 (off = 4): advance intervals alternate 20, 12, 20, 12; each pair sums to 32.
- cmd_stop during step 5, then cmd_play 50 ticks later:
  - No advance while paused; step_idx holds 5, paused = 1.
  - On resume, advance occurs the next tick with step_idx = 6.
  - A second cmd_stop instead gives STOPPED with step_idx = 0.
- sps_load of 32 mid-step with sps = 8:
  - The current step still lasts 8 ticks.
  - The next interval is 32.
  - sps_in = 3 is clamped so the interval becomes 8.
- cmd_play and cmd_stop in the same tick from STOPPED: state stays STOPPED and no advance is issued. Asserting reset mid-step clears all outputs immediately, without waiting for a clock edge.
